// File: rtl/l1d_cache_ctrl_nway.sv
// rtl/l1d_cache_ctrl_nway.sv - N-way write-back L1D controller with tree PLRU and latched victim way
// Optional performance counters are built when L1D_PERF_CNT_EN is defined.
module l1d_cache_ctrl_nway #(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 8,
  localparam int WAY_BITS = $clog2(NUM_WAYS),
  localparam int SET_BITS = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [SET_BITS-1:0] set_idx,
  input  logic [NUM_WAYS-1:0] hit_way,
  input  logic [NUM_WAYS-1:0] valid_way,
  input  logic [NUM_WAYS-1:0] dirty_way,
  input  logic                pmem_resp,
  output logic                mem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic                pmem_addr_sel,
  output logic [WAY_BITS-1:0] way_sel,
  output logic                load_tag,
  output logic                load_data,
  output logic                load_valid,
  output logic                data_in_sel,
  output logic                set_dirty,
  output logic                clr_dirty,
  output logic                miss_pulse,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
  output logic [31:0]         wb_count
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t              state_q, state_d;
  logic [WAY_BITS-1:0] victim_q;
  logic [NUM_WAYS-2:0] plru_q [NUM_SETS];

  function automatic logic [WAY_BITS-1:0] first_one(input logic [NUM_WAYS-1:0] v);
    logic [WAY_BITS-1:0] idx;
    idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (v[i]) idx = WAY_BITS'(i);
    return idx;
  endfunction

  // Heap walk: node bit 0 steers to the lower half, 1 to the upper half.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [WAY_BITS-1:0] node, w;
    logic                b;
    node = '0;
    w    = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b    = bits[node];
      w    = (w << 1) | WAY_BITS'(b);
      node = (node << 1) + WAY_BITS'(1) + WAY_BITS'(b);
    end
    return w;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                      input logic [WAY_BITS-1:0] w);
    logic [NUM_WAYS-2:0] nb;
    logic [WAY_BITS-1:0] node;
    logic                b;
    nb   = bits;
    node = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b        = w[WAY_BITS-1-l];
      nb[node] = ~b;
      node     = (node << 1) + WAY_BITS'(1) + WAY_BITS'(b);
    end
    return nb;
  endfunction

  logic                req, is_hit, idle_hit, idle_miss;
  logic [WAY_BITS-1:0] hit_idx, victim_d;

  assign req       = mem_read | mem_write;
  assign is_hit    = |hit_way;
  assign idle_hit  = (state_q == IDLE) && req && is_hit;
  assign idle_miss = (state_q == IDLE) && req && !is_hit;
  assign hit_idx   = first_one(hit_way);
  assign victim_d  = (&valid_way) ? plru_victim(plru_q[set_idx]) : first_one(~valid_way);

  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b1;
    way_sel       = victim_q;
    load_tag      = 1'b0;
    load_data     = 1'b0;
    load_valid    = 1'b0;
    data_in_sel   = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    miss_pulse    = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_hit) begin
          way_sel  = hit_idx;
          mem_resp = 1'b1;
          if (mem_write) begin
            load_data   = 1'b1;
            data_in_sel = 1'b1;
            set_dirty   = ~dirty_way[hit_idx];
          end
        end else if (idle_miss) begin
          way_sel = victim_d;
          if (valid_way[victim_d] && dirty_way[victim_d]) begin
            state_d = WRITEBACK;
          end else begin
            state_d    = FILL;
            miss_pulse = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          clr_dirty  = 1'b1;
          miss_pulse = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        pmem_read     = 1'b1;
        pmem_addr_sel = 1'b0;
        clr_dirty     = 1'b1;
        load_tag      = pmem_resp;
        load_data     = pmem_resp;
        load_valid    = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (idle_miss) victim_q <= victim_d;
      // Fills leave PLRU alone; the replayed hit performs the touch.
      if (idle_hit) plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_idx);
    end
  end

`ifdef L1D_PERF_CNT_EN
  logic [31:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      if (idle_hit && hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
      if (miss_pulse && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
      if (state_q == WRITEBACK && pmem_resp && wb_q != 32'hFFFF_FFFF) wb_q <= wb_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l1d_cache_ctrl_nway.sv
// tb/tb_l1d_cache_ctrl_nway.sv - directed scoreboard bench for l1d_cache_ctrl_nway
module tb_l1d_cache_ctrl_nway;

  logic        clk = 1'b0;
  logic        rst_n, mem_read, mem_write, pmem_resp;
  logic [2:0]  set_idx;
  logic [3:0]  hit_way, valid_way, dirty_way;
  logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [1:0]  way_sel;
  logic        load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty, miss_pulse;
  logic [31:0] hit_count, miss_count, wb_count;

  int passed = 0, total = 0, failed = 0;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  l1d_cache_ctrl_nway #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_way(hit_way), .valid_way(valid_way), .dirty_way(dirty_way),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
    .load_tag(load_tag), .load_data(load_data), .load_valid(load_valid),
    .data_in_sel(data_in_sel), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
    .miss_pulse(miss_pulse), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input string tag);
    logic [1:0] e;
    int n = 0;
    while (mem_resp !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " mem_resp"}, {31'd0, mem_resp}, 32'd1);
    check({tag, " sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " way_sel"}, {30'd0, way_sel}, {30'd0, e});
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; mem_read = 0; mem_write = 0; pmem_resp = 0;
    set_idx = 0; hit_way = 0; valid_way = 0; dirty_way = 0;
    repeat (2) @(posedge clk); #1;
    check("rst mem_resp", {31'd0, mem_resp}, 0);
    check("rst pmem_read", {31'd0, pmem_read}, 0);
    check("rst pmem_write", {31'd0, pmem_write}, 0);
    check("rst way_sel", {30'd0, way_sel}, 0);
    check("rst addr_sel", {31'd0, pmem_addr_sel}, 1);
    check("rst hit_count", hit_count, 0);
    rst_n = 1;
    tick();

    // Cold miss into an empty set, fill after a few cycles, then replayed hit.
    mem_read = 1; set_idx = 3; #1;
    check("s1 miss_pulse", {31'd0, miss_pulse}, 1);
    check("s1 victim", {30'd0, way_sel}, 0);
    check("s1 no resp", {31'd0, mem_resp}, 0);
    exp_miss++;
    tick();
    check("s1 fill pmem_read", {31'd0, pmem_read}, 1);
    check("s1 fill addr_sel", {31'd0, pmem_addr_sel}, 0);
    check("s1 fill no load", {31'd0, load_data}, 0);
    check("s1 fill clr_dirty", {31'd0, clr_dirty}, 1);
    repeat (4) tick();
    pmem_resp = 1; #1;
    check("s1 load_tag", {31'd0, load_tag}, 1);
    check("s1 load_data", {31'd0, load_data}, 1);
    check("s1 load_valid", {31'd0, load_valid}, 1);
    check("s1 data_in_sel", {31'd0, data_in_sel}, 0);
    tick();
    pmem_resp = 0; hit_way = 4'b0001; valid_way = 4'b0001;
    exp_q.push_back(2'd0); exp_hit++; #1;
    expect_resp("s1 hit");
    tick();

    // Fresh set: hit way 0, then all-valid miss picks way 2; request dropped mid-fill.
    set_idx = 5; valid_way = 4'b1111; hit_way = 4'b0001;
    exp_q.push_back(2'd0); exp_hit++; #1;
    expect_resp("s2 hit");
    tick();
    hit_way = 4'b0000; #1;
    check("s2 plru victim", {30'd0, way_sel}, 2);
    check("s2 miss_pulse", {31'd0, miss_pulse}, 1);
    exp_miss++;
    tick();
    check("s2 fill", {31'd0, pmem_read}, 1);
    check("s2 victim_q", {30'd0, way_sel}, 2);
    mem_read = 0;
    tick();
    pmem_resp = 1; #1;
    check("s2 dropped load_valid", {31'd0, load_valid}, 1);
    tick();
    pmem_resp = 0; #1;
    check("s2 idle pmem_read", {31'd0, pmem_read}, 0);
    check("s2 idle no resp", {31'd0, mem_resp}, 0);
    check("s2 idle addr_sel", {31'd0, pmem_addr_sel}, 1);

    // Write hits (read+write together counts as a write).
    set_idx = 1; mem_write = 1; mem_read = 1; hit_way = 4'b0010; dirty_way = 4'b0000;
    exp_q.push_back(2'd1); exp_hit++; #1;
    check("s3 load_data", {31'd0, load_data}, 1);
    check("s3 data_in_sel", {31'd0, data_in_sel}, 1);
    check("s3 set_dirty", {31'd0, set_dirty}, 1);
    expect_resp("s3 wr");
    tick();
    dirty_way = 4'b0010; exp_q.push_back(2'd1); exp_hit++; #1;
    check("s3 dirty no set_dirty", {31'd0, set_dirty}, 0);
    check("s3 dirty load_data", {31'd0, load_data}, 1);
    expect_resp("s3 wr dirty");
    tick();
    mem_write = 0; mem_read = 0; hit_way = 0; dirty_way = 0;
    tick();

    // Steer set 6 PLRU to way 3, then dirty miss through WRITEBACK and FILL.
    set_idx = 6; mem_read = 1; hit_way = 4'b0100;
    exp_q.push_back(2'd2); exp_hit++; #1;
    expect_resp("s4 hit2");
    tick();
    hit_way = 4'b0001; exp_q.push_back(2'd0); exp_hit++; #1;
    expect_resp("s4 hit0");
    tick();
    hit_way = 4'b0000; dirty_way = 4'b1000; #1;
    check("s4 victim", {30'd0, way_sel}, 3);
    check("s4 no miss_pulse", {31'd0, miss_pulse}, 0);
    tick();
    check("s4 wb pmem_write", {31'd0, pmem_write}, 1);
    check("s4 wb addr_sel", {31'd0, pmem_addr_sel}, 1);
    check("s4 wb way_sel", {30'd0, way_sel}, 3);
    check("s4 wb pmem_read", {31'd0, pmem_read}, 0);
    tick();
    check("s4 wb hold", {31'd0, pmem_write}, 1);
    pmem_resp = 1; #1;
    check("s4 wb clr_dirty", {31'd0, clr_dirty}, 1);
    check("s4 wb miss_pulse", {31'd0, miss_pulse}, 1);
    exp_miss++; exp_wb++;
    tick();
    pmem_resp = 0; #1;
    check("s4 fill pmem_read", {31'd0, pmem_read}, 1);
    check("s4 fill pmem_write", {31'd0, pmem_write}, 0);
    check("s4 fill way_sel", {30'd0, way_sel}, 3);
    pmem_resp = 1; #1;
    check("s4 fill load_tag", {31'd0, load_tag}, 1);
    tick();
    pmem_resp = 0; hit_way = 4'b1000; exp_q.push_back(2'd3); exp_hit++; #1;
    expect_resp("s4 replay");
    tick();
    mem_read = 0; hit_way = 0; #1;
`ifdef L1D_PERF_CNT_EN
    check("hit_count", hit_count, exp_hit);
    check("miss_count", miss_count, exp_miss);
    check("wb_count", wb_count, exp_wb);
`else
    check("hit_count", hit_count, 0);
    check("miss_count", miss_count, 0);
    check("wb_count", wb_count, 0);
`endif

    // Reset asserted in the middle of a WRITEBACK.
    set_idx = 7; dirty_way = 4'b1111; mem_read = 1; #1;
    check("s5 victim", {30'd0, way_sel}, 0);
    tick();
    check("s5 wb", {31'd0, pmem_write}, 1);
    #2 rst_n = 0; #1;
    check("s5 rst pmem_write", {31'd0, pmem_write}, 0);
    check("s5 rst pmem_read", {31'd0, pmem_read}, 0);
    check("s5 rst hit_count", hit_count, 0);
    check("s5 rst miss_count", miss_count, 0);
    check("s5 rst wb_count", wb_count, 0);
    mem_read = 0;
    tick();
    rst_n = 1;
    set_idx = 6; dirty_way = 4'b0000; mem_read = 1; #1;
    check("s5 post-rst victim", {30'd0, way_sel}, 0);
    check("s5 post-rst miss_pulse", {31'd0, miss_pulse}, 1);
    tick();
    check("s5 post-rst fill", {31'd0, pmem_read}, 1);
    mem_read = 0; pmem_resp = 1;
    tick();
    pmem_resp = 0;
    check("sb drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
